// File: rtl/rx_frame_writer_pkg.sv
// Shared types for the RX frame writer: descriptor record, frame FSM states
// and the default frame-size limit.
package rx_pkg;
   localparam int SIZE_W  = 11;
   localparam int LEN_W   = 11;
   localparam int MAX_LEN = 1518;

   typedef struct packed {
      logic [SIZE_W-1:0] addr;
      logic [LEN_W-1:0]  len;
   } desc_t;

   typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;
endpackage

// File: rtl/rx_frame_writer_desc_fifo.sv
// Show-ahead descriptor FIFO; the head entry is presented combinationally.
module desc_fifo
   import rx_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  desc_t       din,
   input  logic        pop,
   output desc_t       dout,
   output logic        full,
   output logic        empty,
   output logic [AW:0] count
);
   desc_t         mem_q [DEPTH];
   logic [AW-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
   logic [AW:0]   count_q, count_d;
   logic          push_ok, pop_ok;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem_q[rd_idx_q];
   // When full, a simultaneous pop frees the slot the push lands in.
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);

   always_comb begin
      wr_idx_d = wr_idx_q;
      rd_idx_d = rd_idx_q;
      count_d  = count_q;
      if (push_ok) wr_idx_d = wr_idx_q + 1'b1;
      if (pop_ok)  rd_idx_d = rd_idx_q + 1'b1;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_idx_q <= '0;
         rd_idx_q <= '0;
         count_q  <= '0;
      end else begin
         wr_idx_q <= wr_idx_d;
         rd_idx_q <= rd_idx_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_idx_q] <= din;
   end
endmodule

// File: rtl/rx_frame_writer.sv
// Writes RX MAC frames into a circular EBR buffer, commits clean frames as
// (addr, len) descriptors and rewinds the write pointer for discarded ones.
module rx_frame_writer #(
   parameter int DATA_WIDTH = 8,
   parameter int SIZE       = 2048,
   parameter int SIZE_WIDTH = $clog2(SIZE),
   parameter int LEN_WIDTH  = 11,
   parameter int MAX_LEN    = rx_pkg::MAX_LEN,
   parameter int DESC_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   input  logic                  s_last,
   input  logic                  s_err,
   output logic                  mem_wr_en,
   output logic [SIZE_WIDTH-1:0] mem_wr_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   output logic                  desc_valid,
   input  logic                  desc_ready,
   output logic [SIZE_WIDTH-1:0] desc_addr,
   output logic [LEN_WIDTH-1:0]  desc_len,
   input  logic                  rel_valid,
   input  logic [LEN_WIDTH-1:0]  rel_len,
   output logic                  drop_pulse,
   output logic [15:0]           drop_count
);
   import rx_pkg::*;

   localparam int PW = SIZE_WIDTH + 1;
   localparam int CW = $clog2(DESC_DEPTH) + 1;

   state_t                state_q, state_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         commit_ptr_q, commit_ptr_d;
   logic [PW-1:0]         rel_ptr_q, rel_ptr_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic                  mem_wr_en_q, mem_wr_en_d;
   logic [SIZE_WIDTH-1:0] mem_wr_addr_q, mem_wr_addr_d;
   logic [DATA_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
   logic                  push_q, push_d;
   desc_t                 push_desc_q, push_desc_d;
   logic                  drop_pulse_q, drop_pulse_d;
   logic [15:0]           drop_count_q, drop_count_d;

   logic [PW-1:0]         used;
   logic                  full, can_write, fifo_room, discard;
   logic                  fifo_full, fifo_empty;
   logic [CW-1:0]         fifo_count;
   desc_t                 fifo_dout;

   assign used      = wr_ptr_q - rel_ptr_q;
   assign full      = (used == PW'(SIZE));
   assign can_write = ~full && (len_q < LEN_WIDTH'(MAX_LEN));
   // A push still in flight to the FIFO already owns a slot.
   assign fifo_room = ~fifo_full &&
                      ((CW+1)'(fifo_count) + (CW+1)'(push_q) < (CW+1)'(DESC_DEPTH));

   always_comb begin
      state_d       = state_q;
      wr_ptr_d      = wr_ptr_q;
      commit_ptr_d  = commit_ptr_q;
      rel_ptr_d     = rel_valid ? rel_ptr_q + PW'(rel_len) : rel_ptr_q;
      len_d         = len_q;
      mem_wr_en_d   = 1'b0;
      mem_wr_addr_d = mem_wr_addr_q;
      mem_wr_data_d = mem_wr_data_q;
      push_d        = 1'b0;
      push_desc_d   = push_desc_q;
      drop_pulse_d  = 1'b0;
      drop_count_d  = drop_count_q;
      discard       = 1'b0;
      case (state_q)
         IDLE, WRITE: begin
            if (s_valid) begin
               if (can_write) begin
                  mem_wr_en_d   = 1'b1;
                  mem_wr_addr_d = wr_ptr_q[SIZE_WIDTH-1:0];
                  mem_wr_data_d = s_data;
                  wr_ptr_d      = wr_ptr_q + 1'b1;
                  len_d         = len_q + 1'b1;
                  state_d       = WRITE;
               end else begin
                  state_d = DROP;
               end
               if (s_last) begin
                  if (can_write && !s_err && fifo_room) begin
                     push_d           = 1'b1;
                     push_desc_d.addr = commit_ptr_q[SIZE_WIDTH-1:0];
                     push_desc_d.len  = len_q + 1'b1;
                     commit_ptr_d     = wr_ptr_q + 1'b1;
                     len_d            = '0;
                     state_d          = IDLE;
                  end else begin
                     discard = 1'b1;
                  end
               end
            end
         end
         DROP: if (s_valid && s_last) discard = 1'b1;
         default: state_d = IDLE;
      endcase
      if (discard) begin
         wr_ptr_d     = commit_ptr_q;
         len_d        = '0;
         state_d      = IDLE;
         drop_pulse_d = 1'b1;
         if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         wr_ptr_q      <= '0;
         commit_ptr_q  <= '0;
         rel_ptr_q     <= '0;
         len_q         <= '0;
         mem_wr_en_q   <= 1'b0;
         mem_wr_addr_q <= '0;
         mem_wr_data_q <= '0;
         push_q        <= 1'b0;
         push_desc_q   <= '0;
         drop_pulse_q  <= 1'b0;
         drop_count_q  <= '0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         commit_ptr_q  <= commit_ptr_d;
         rel_ptr_q     <= rel_ptr_d;
         len_q         <= len_d;
         mem_wr_en_q   <= mem_wr_en_d;
         mem_wr_addr_q <= mem_wr_addr_d;
         mem_wr_data_q <= mem_wr_data_d;
         push_q        <= push_d;
         push_desc_q   <= push_desc_d;
         drop_pulse_q  <= drop_pulse_d;
         drop_count_q  <= drop_count_d;
      end
   end

   // Push is delayed one cycle so the descriptor trails its last EBR write.
   desc_fifo #(.DEPTH(DESC_DEPTH)) u_desc_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_q),
      .din   (push_desc_q),
      .pop   (desc_ready),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign mem_wr_en   = mem_wr_en_q;
   assign mem_wr_addr = mem_wr_addr_q;
   assign mem_wr_data = mem_wr_data_q;
   assign desc_valid  = ~fifo_empty;
   assign desc_addr   = fifo_dout.addr;
   assign desc_len    = fifo_dout.len;
   assign drop_pulse  = drop_pulse_q;
   assign drop_count  = drop_count_q;
endmodule

// File: tb/tb_rx_frame_writer.sv
// Directed bench for rx_frame_writer with a frame-level reference model.
module tb_rx_frame_writer;
   localparam int SIZE = 2048;
   localparam int MAXL = 1518;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  s_data = '0;
   logic        s_valid = 1'b0, s_last = 1'b0, s_err = 1'b0;
   logic        mem_wr_en;
   logic [10:0] mem_wr_addr;
   logic [7:0]  mem_wr_data;
   logic        desc_valid;
   logic        desc_ready = 1'b0;
   logic [10:0] desc_addr;
   logic [10:0] desc_len;
   logic        rel_valid = 1'b0;
   logic [10:0] rel_len = '0;
   logic        drop_pulse;
   logic [15:0] drop_count;

   always #5 clk = ~clk;

   rx_frame_writer dut (
      .clk(clk), .rst(rst),
      .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_err(s_err),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .desc_valid(desc_valid), .desc_ready(desc_ready),
      .desc_addr(desc_addr), .desc_len(desc_len),
      .rel_valid(rel_valid), .rel_len(rel_len),
      .drop_pulse(drop_pulse), .drop_count(drop_count)
   );

   typedef struct { int addr; int data; } wr_t;

   int   checks = 0, errors = 0;
   wr_t  exp_wr[$];
   int   exp_da[$], exp_dl[$];
   logic [7:0] ram  [SIZE];
   logic [7:0] mram [SIZE];
   int   m_commit = 0, m_rel = 0, m_popped = 0, m_drop = 0, pulse_cnt = 0;
   logic prev_dv = 1'b0;
   int   prev_a = -1, prev_l = -1;

   function automatic logic [10:0] idx(int a);
      return 11'(a % SIZE);
   endfunction

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Per-cycle compare: EBR writes against the model, descriptor data already in RAM.
   always @(negedge clk) begin
      if (desc_valid && (!prev_dv || int'(desc_addr) != prev_a || int'(desc_len) != prev_l)) begin
         int bad;
         bad = 0;
         for (int i = 0; i < int'(desc_len); i++)
            if (ram[idx(int'(desc_addr) + i)] !== mram[idx(int'(desc_addr) + i)]) bad++;
         chk("desc_data_in_ram", bad, 0);
      end
      prev_dv = desc_valid;
      prev_a  = int'(desc_addr);
      prev_l  = int'(desc_len);
      if (mem_wr_en === 1'b1) begin
         wr_t e;
         if (exp_wr.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: got addr %0d data %0d expected none", mem_wr_addr, mem_wr_data);
         end else begin
            e = exp_wr.pop_front();
            chk("wr_addr", int'(mem_wr_addr), e.addr);
            chk("wr_data", int'(mem_wr_data), e.data);
         end
         ram[mem_wr_addr] = mem_wr_data;
      end
      if (drop_pulse === 1'b1) pulse_cnt++;
   end

   // Frame-level model: a frame writes its prefix until full or MAX_LEN,
   // and commits only if every byte landed, no error and a descriptor slot is free.
   task automatic send_frame(int len, int base, bit err);
      int used, nwr;
      used = m_commit - m_rel;
      nwr  = len;
      if (nwr > MAXL) nwr = MAXL;
      if (nwr > SIZE - used) nwr = SIZE - used;
      for (int i = 0; i < nwr; i++) begin
         exp_wr.push_back('{(m_commit + i) % SIZE, (base + i) & 255});
         mram[idx(m_commit + i)] = 8'(base + i);
      end
      if (nwr == len && !err && exp_da.size() < 4) begin
         exp_da.push_back(m_commit % SIZE);
         exp_dl.push_back(len);
         m_commit += len;
      end else begin
         m_drop++;
      end
      for (int k = 0; k < len; k++) begin
         @(negedge clk);
         s_valid = 1'b1;
         s_data  = 8'(base + k);
         s_last  = (k == len - 1);
         s_err   = err && (k == len - 1);
      end
      @(negedge clk);
      s_valid = 1'b0; s_last = 1'b0; s_err = 1'b0;
   endtask

   task automatic pop_desc(output int a, output int l);
      int n, ea, el;
      n = 0;
      while (desc_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      if (desc_valid !== 1'b1) begin
         checks++; errors++;
         $display("FAIL desc_timeout: got no descriptor expected one within 20 cycles");
         a = -1; l = -1;
         return;
      end
      a = int'(desc_addr);
      l = int'(desc_len);
      if (exp_da.size() == 0) begin
         checks++; errors++;
         $display("FAIL desc_unexpected: got addr %0d len %0d expected none", a, l);
      end else begin
         ea = exp_da.pop_front();
         el = exp_dl.pop_front();
         chk("desc_addr_model", a, ea);
         chk("desc_len_model", l, el);
      end
      m_popped += l;
      desc_ready = 1'b1;
      @(negedge clk);
      desc_ready = 1'b0;
   endtask

   task automatic release_bytes(int n);
      chk("release_le_popped", int'(m_rel + n <= m_popped), 1);
      @(negedge clk);
      rel_valid = 1'b1; rel_len = 11'(n);
      @(negedge clk);
      rel_valid = 1'b0;
      m_rel += n;
   endtask

   task automatic drain();
      repeat (4) @(negedge clk);
      chk("writes_drained", exp_wr.size(), 0);
   endtask

   task automatic check_drops(string name, int lit);
      chk(name, int'(drop_count), lit);
      chk("drop_count_model", int'(drop_count), m_drop);
      chk("drop_pulses", pulse_cnt, m_drop);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_err = 1'b0;
      rel_valid = 1'b0; desc_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_commit = 0; m_rel = 0; m_popped = 0; m_drop = 0; pulse_cnt = 0;
      exp_da.delete(); exp_dl.delete();
   endtask

   initial begin
      int a, l, bad;
      for (int i = 0; i < SIZE; i++) begin ram[i] = 8'h00; mram[i] = 8'h00; end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mem_wr_en", int'(mem_wr_en), 0);
      chk("rst_desc_valid", int'(desc_valid), 0);
      chk("rst_drop_pulse", int'(drop_pulse), 0);
      chk("rst_drop_count", int'(drop_count), 0);

      // Single clean 64-byte frame
      send_frame(64, 0, 0);
      pop_desc(a, l);
      chk("t1_addr", a, 0); chk("t1_len", l, 64);
      drain();
      bad = 0;
      for (int i = 0; i < 64; i++) if (ram[i] !== 8'(i)) bad++;
      chk("t1_ram", bad, 0);
      check_drops("t1_drop_count", 0);
      release_bytes(64);

      // Errored frame then clean frame, then single-byte frame
      do_reset();
      send_frame(100, 100, 1);
      drain();
      check_drops("t2_drop_count", 1);
      send_frame(10, 200, 0);
      pop_desc(a, l);
      chk("t2_addr", a, 0); chk("t2_len", l, 10);
      drain();
      bad = 0;
      for (int i = 0; i < 10; i++) if (ram[i] !== 8'(200 + i)) bad++;
      chk("t2_ram", bad, 0);
      send_frame(1, 7, 0);
      pop_desc(a, l);
      chk("t2_single_addr", a, 10); chk("t2_single_len", l, 1);

      // Wrap around the end of the buffer
      do_reset();
      send_frame(1000, 0, 0); pop_desc(a, l); release_bytes(1000);
      send_frame(1000, 0, 0); pop_desc(a, l); release_bytes(1000);
      send_frame(60, 50, 0);
      pop_desc(a, l);
      chk("t3_addr", a, 2000); chk("t3_len", l, 60);
      drain();
      bad = 0;
      for (int i = 0; i < 60; i++) if (ram[idx(2000 + i)] !== 8'(50 + i)) bad++;
      chk("t3_ram", bad, 0);

      // Oversized stream, then rewind check
      do_reset();
      send_frame(2100, 0, 0);
      drain();
      check_drops("t4_oversize_drops", 1);
      send_frame(5, 9, 0);
      pop_desc(a, l);
      chk("t4_rewind_addr", a, 0); chk("t4_rewind_len", l, 5);

      // Completely full buffer: next frame drops at its first byte
      do_reset();
      send_frame(1024, 0, 0); pop_desc(a, l);
      send_frame(1024, 1, 0); pop_desc(a, l);
      send_frame(4, 3, 0);
      drain();
      check_drops("t4_full_drops", 1);
      release_bytes(1024);
      send_frame(4, 3, 0);
      pop_desc(a, l);
      chk("t4_after_full_addr", a, 0); chk("t4_after_full_len", l, 4);

      // Descriptor FIFO full
      do_reset();
      for (int k = 0; k < 5; k++) send_frame(20, k * 20, 0);
      drain();
      check_drops("t5_drop_count", 1);
      for (int k = 0; k < 4; k++) begin
         pop_desc(a, l);
         chk("t5_addr", a, k * 20); chk("t5_len", l, 20);
      end
      send_frame(8, 0, 0);
      pop_desc(a, l);
      chk("t5_next_addr", a, 80); chk("t5_next_len", l, 8);

      // Reset in the middle of a frame
      do_reset();
      for (int k = 0; k < 30; k++) begin
         exp_wr.push_back('{k, (k + 33) & 255});
         mram[idx(k)] = 8'(k + 33);
         @(negedge clk);
         s_valid = 1'b1; s_data = 8'(k + 33); s_last = 1'b0; s_err = 1'b0;
      end
      do_reset();
      @(negedge clk);
      chk("t6_desc_valid", int'(desc_valid), 0);
      chk("t6_drop_count", int'(drop_count), 0);
      chk("t6_writes_drained", exp_wr.size(), 0);
      send_frame(8, 0, 0);
      pop_desc(a, l);
      chk("t6_addr", a, 0); chk("t6_len", l, 8);

      // Exactly MAX_LEN bytes is accepted
      do_reset();
      send_frame(MAXL, 0, 0);
      pop_desc(a, l);
      chk("t7_addr", a, 0); chk("t7_len", l, 1518);
      drain();
      check_drops("t7_drop_count", 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
